// File: rtl/fp16_pkg.sv
// fp16_pkg: shared encodings and field widths for the fp16 multiplier completion stage.
package fp16_pkg;
    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_SIG = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_INF  = 16'h7C00;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;
endpackage

// File: rtl/dff.sv
// dff: plain register with asynchronous active-low reset to a fixed value.
module dff #(
    parameter int         W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) q <= RESET_VAL;
        else          q <= d;
    end
endmodule

// File: rtl/fp16_classify.sv
// fp16_classify: sorts an unsigned fp16 magnitude into zero/normal/inf/nan; subnormals count as zero.
module fp16_classify
    import fp16_pkg::*;
#(
    parameter int EXP_WIDTH  = EXP_W,
    parameter int FRAC_WIDTH = FRAC_W
) (
    input  logic [EXP_WIDTH+FRAC_WIDTH-1:0] op,
    output fp_class_t                       cls
);
    logic exp_zero, exp_max, frac_zero;

    assign exp_zero  = op[EXP_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH] == '0;
    assign exp_max   = &op[EXP_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
    assign frac_zero = op[FRAC_WIDTH-1:0] == '0;

    always_comb cls = exp_zero ? ZERO : !exp_max ? NORM : frac_zero ? INF : NAN;
endmodule

// File: rtl/fp16_mul_exp_packer.sv
// fp16_mul_exp_packer: completes an fp16 multiply -- exponent, specials, over/underflow, packed valid/ready output.
// Optional FP_MUL_FLAGS_EN adds flags = {invalid, overflow, underflow, zero_result}.
module fp16_mul_exp_packer
    import fp16_pkg::*;
#(
    parameter int EXP_WIDTH  = EXP_W,
    parameter int FRAC_WIDTH = FRAC_W,
    parameter int EXP_BIAS   = BIAS
) (
    input  logic                            clk,
    input  logic                            reset_b,
    input  logic                            start,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   op_a,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   op_b,
    input  logic                            sig_valid,
    input  logic [FRAC_WIDTH-1:0]           sig_result,
    input  logic                            sig_msb,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]   out_data
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [3:0]                      flags
`endif
);
    localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int EW = EXP_WIDTH + 2;

    localparam logic signed [EW-1:0] BIAS_S = EW'(EXP_BIAS);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
    localparam logic [W-2:0]   INF_MAG = {{EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};

    logic [1:0] state, state_nxt;
    logic accept, finish, handoff;
    logic [EXP_WIDTH-1:0] exp_a, exp_b;
    logic sign;
    fp_class_t cls_a, cls_b, cls_a_in, cls_b_in;
    logic signed [EW-1:0] e;
    logic nan_case, inf_case, zero_case, ovf, unf;
    logic [W-1:0] result;

    fp16_classify #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_cls_a (.op(op_a[W-2:0]), .cls(cls_a_in));
    fp16_classify #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_cls_b (.op(op_b[W-2:0]), .cls(cls_b_in));

    assign accept  = state == IDLE && start;
    assign finish  = state == WAIT_SIG && sig_valid;
    assign handoff = state == DONE && out_ready;
    assign busy    = state != IDLE;

    always_comb state_nxt = accept ? WAIT_SIG : finish ? DONE : handoff ? IDLE : state;

    dff #(.W(2), .RESET_VAL(IDLE)) u_state (.clk(clk), .reset_b(reset_b), .d(state_nxt), .q(state));

    // Specials take priority over exponent range; the sig handler result is simply discarded for them.
    always_comb begin
        e = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S
            + $signed({{(EW-1){1'b0}}, sig_msb});
        nan_case  = cls_a == NAN || cls_b == NAN || (cls_a == INF && cls_b == ZERO)
                    || (cls_a == ZERO && cls_b == INF);
        inf_case  = cls_a == INF || cls_b == INF;
        zero_case = cls_a == ZERO || cls_b == ZERO;
        ovf       = e >= E_MAX;
        unf       = e <= E_ZERO;
        result    = nan_case  ? QNAN :
                    inf_case  ? {sign, INF_MAG} :
                    zero_case ? {sign, {(W-1){1'b0}}} :
                    ovf       ? {sign, INF_MAG} :
                    unf       ? {sign, {(W-1){1'b0}}} :
                                {sign, e[EXP_WIDTH-1:0], sig_result};
    end

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] flags_nxt;
    logic       regular;
    always_comb begin
        regular   = !nan_case && !inf_case && !zero_case;
        flags_nxt = {nan_case, regular && ovf, regular && unf, result[W-2:0] == '0};
    end
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            exp_a     <= '0;
            exp_b     <= '0;
            sign      <= 1'b0;
            cls_a     <= ZERO;
            cls_b     <= ZERO;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef FP_MUL_FLAGS_EN
            flags     <= '0;
`endif
        end else begin
            if (accept) begin
                exp_a <= op_a[W-2:FRAC_WIDTH];
                exp_b <= op_b[W-2:FRAC_WIDTH];
                sign  <= op_a[W-1] ^ op_b[W-1];
                cls_a <= cls_a_in;
                cls_b <= cls_b_in;
            end
            if (finish) begin
                out_data  <= result;
                out_valid <= 1'b1;
`ifdef FP_MUL_FLAGS_EN
                flags     <= flags_nxt;
`endif
            end else if (handoff) begin
                out_valid <= 1'b0;
`ifdef FP_MUL_FLAGS_EN
                flags     <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_fp16_mul_exp_packer.sv
// tb_fp16_mul_exp_packer: directed vectors against a spec-level fp16 product model plus literal expectations.
module tb_fp16_mul_exp_packer;
    logic        clk = 0, reset_b = 0, start = 0, sig_valid = 0, sig_msb = 0, out_ready = 0;
    logic [15:0] op_a = 0, op_b = 0;
    logic [9:0]  sig_result = 0;
    logic        busy, out_valid;
    logic [15:0] out_data;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  flags;
`endif

    int checks = 0, errors = 0;
    bit chk_en = 0;
    logic m_busy = 0, m_valid = 0;
    logic [19:0] m_exp = 0;

    fp16_mul_exp_packer dut (
        .clk(clk), .reset_b(reset_b), .start(start), .op_a(op_a), .op_b(op_b),
        .sig_valid(sig_valid), .sig_result(sig_result), .sig_msb(sig_msb),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef FP_MUL_FLAGS_EN
        , .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {invalid, overflow, underflow, zero_result, packed product}.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [9:0] sr, input logic msb);
        int ea = int'(a[14:10]);
        int eb = int'(b[14:10]);
        int e;
        logic s = a[15] ^ b[15];
        bit an = ea == 31 && a[9:0] != 0, ai = ea == 31 && a[9:0] == 0, az = ea == 0;
        bit bn = eb == 31 && b[9:0] != 0, bi = eb == 31 && b[9:0] == 0, bz = eb == 0;
        bit inv = 0, ov = 0, un = 0;
        logic [15:0] d;
        if (an || bn || (ai && bz) || (az && bi)) begin d = 16'h7E00; inv = 1; end
        else if (ai || bi) d = {s, 15'h7C00};
        else if (az || bz) d = {s, 15'h0000};
        else begin
            e = ea + eb - 15 + int'(msb);
            if (e >= 31)     begin d = {s, 15'h7C00}; ov = 1; end
            else if (e <= 0) begin d = {s, 15'h0000}; un = 1; end
            else d = {s, e[4:0], sr};
        end
        return {inv, ov, un, d[14:0] == 15'h0, d};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) check("out_data", 32'(out_data), 32'(m_exp[15:0]));
`ifdef FP_MUL_FLAGS_EN
            check("flags", 32'(flags), m_valid ? 32'(m_exp[19:16]) : 32'd0);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [9:0] sr,
                          input logic msb, input int lat, input int stall, input logic [15:0] lit);
        start = 1; op_a = a; op_b = b;
        tick;
        start = 0; op_a = 16'($urandom); op_b = 16'($urandom); m_busy = 1;
        repeat (lat) tick;
        sig_valid = 1; sig_result = sr; sig_msb = msb;
        tick;
        sig_valid = 0; sig_result = 10'($urandom); sig_msb = 1'($urandom);
        m_valid = 1; m_exp = model(a, b, sr, msb);
        check("model_vs_hand", 32'(m_exp[15:0]), 32'(lit));
        check("dut_vs_hand", 32'(out_data), 32'(lit));
        for (int i = 0; i < stall; i++) begin
            start = 1; op_a = 16'($urandom); op_b = 16'($urandom);
            tick;
        end
        out_ready = 1; start = 1;
        tick;
        out_ready = 0; start = 0; m_valid = 0; m_busy = 0;
        tick;
    endtask

    initial begin
        repeat (2) tick;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'h0000);
        reset_b = 1; chk_en = 1;
        tick;

        run_op(16'h3E00, 16'h4000, 10'h200, 1'b0, 0, 0, 16'h4200);
        run_op(16'hC000, 16'h4200, 10'h200, 1'b0, 2, 0, 16'hC600);
        run_op(16'h7BFF, 16'h7BFF, 10'h3FF, 1'b1, 1, 0, 16'h7C00);
        run_op(16'h0400, 16'h0400, 10'h000, 1'b0, 0, 0, 16'h0000);
        run_op(16'h7C00, 16'h0000, 10'h155, 1'b0, 3, 0, 16'h7E00);
        run_op(16'hFE01, 16'h3C00, 10'h155, 1'b0, 0, 0, 16'h7E00);
        run_op(16'hFC00, 16'h4000, 10'h155, 1'b1, 0, 0, 16'hFC00);
        run_op(16'h8000, 16'h4200, 10'h155, 1'b0, 0, 0, 16'h8000);
        run_op(16'h7800, 16'h3C00, 10'h155, 1'b0, 0, 0, 16'h7955);
        run_op(16'h7800, 16'h3C00, 10'h155, 1'b1, 0, 0, 16'h7C00);
        run_op(16'h0400, 16'h3C00, 10'h0AA, 1'b0, 0, 0, 16'h04AA);
        run_op(16'h0400, 16'h3800, 10'h0AA, 1'b0, 0, 0, 16'h0000);
        run_op(16'h8400, 16'h3800, 10'h0AA, 1'b1, 0, 0, 16'h84AA);
        run_op(16'h0001, 16'h3C00, 10'h0AA, 1'b0, 0, 0, 16'h0000);
        run_op(16'h3E00, 16'h4000, 10'h200, 1'b0, 1, 10, 16'h4200);

        sig_valid = 1; sig_result = 10'h3FF;
        tick;
        sig_valid = 0;
        repeat (2) tick;

        start = 1; op_a = 16'h3E00; op_b = 16'h4000;
        tick;
        start = 0; m_busy = 1;
        tick;
        reset_b = 0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        m_busy = 0;
        #2 reset_b = 1;
        tick;
        sig_valid = 1; sig_result = 10'h200;
        tick;
        sig_valid = 0;
        repeat (3) tick;

        run_op(16'hC000, 16'h4200, 10'h200, 1'b0, 0, 2, 16'hC600);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
